// File: rtl/fp_mult_param.sv
// fp_mult_param: multi-cycle IEEE-754-style floating-point multiplier.
// The exponent and fraction widths are parameters. It supports four
// rounding modes and reports per-result exception flags
// {invalid, overflow, underflow, inexact}.
// Subnormal operands are flushed to zero on input, and results that
// underflow are flushed to zero on output.
//
// Handshake: start is sampled only in IDLE or DONE. When accepted, a, b and
// rnd_mode are captured on that edge. busy is high while an operation is in
// flight. done is a one-cycle pulse, and p/flags are valid in that cycle and
// held until the next done. A start seen while busy is dropped.
//
// FSM state is held in the enum register state_q (UNPACK, MULT, NORM and
// ROUND are the busy states) so that checkers can bind to it directly.
module fp_mult_param #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   input  logic [1:0]             rnd_mode,
   output logic                   busy,
   output logic                   done,
   output logic [EXP_W+MAN_W:0]   p,
   output logic [3:0]             flags
);

   localparam int W  = 1 + EXP_W + MAN_W;   // packed operand width
   localparam int SW = MAN_W + 1;           // significand width incl. hidden bit
   localparam int PW = 2 * MAN_W + 2;       // full product width
   localparam int XW = EXP_W + 2;           // working exponent width (signed)
   localparam int CW = $clog2(MAN_W + 1);   // multiply step counter width

   localparam logic [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
   localparam logic [XW-1:0] EXP_ONES = XW'((1 << EXP_W) - 1);
   localparam logic [XW-1:0] EXP_ONE  = XW'(1);
   localparam logic [CW-1:0] CNT_INIT = CW'(MAN_W);
   localparam logic [W-1:0]  QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_MULT   = 3'd2,
      S_NORM   = 3'd3,
      S_ROUND  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [1:0]      rnd_q, rnd_d;
   logic            sign_q, sign_d;
   logic [XW-1:0]   exp_q, exp_d;
   logic            spec_q, spec_d;
   logic [W-1:0]    spec_p_q, spec_p_d;
   logic [3:0]      spec_flags_q, spec_flags_d;
   logic [PW-1:0]   mcand_q, mcand_d;
   logic [SW-1:0]   mplier_q, mplier_d;
   logic [PW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [MAN_W-1:0] man_q, man_d;
   logic            g_q, g_d;
   logic            r_q, r_d;
   logic            s_q, s_d;
   logic [W-1:0]    p_q, p_d;
   logic [3:0]      flags_q, flags_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   // Operand field decode (used in UNPACK)
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             sgn;
   logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

   assign ea     = a_q[W-2:MAN_W];
   assign eb     = b_q[W-2:MAN_W];
   assign fa     = a_q[MAN_W-1:0];
   assign fb     = b_q[MAN_W-1:0];
   assign sgn    = a_q[W-1] ^ b_q[W-1];
   // A zero exponent covers both true zero and subnormals (flushed to zero).
   assign zero_a = (ea == '0);
   assign zero_b = (eb == '0);
   assign inf_a  = (ea == '1) && (fa == '0);
   assign inf_b  = (eb == '1) && (fb == '0);
   assign nan_a  = (ea == '1) && (fa != '0);
   assign nan_b  = (eb == '1) && (fb != '0);

   // Normalisation selection: product MSB set means the value is in [2,4)
   logic norm_hi;
   assign norm_hi = acc_q[PW-1];

   // Rounding datapath signals
   logic             grs;
   logic             inc;
   logic [MAN_W+1:0] mant_r;
   logic [XW-1:0]    exp_r;
   logic [MAN_W-1:0] frac_r;
   logic [W-1:0]     inf_res;
   logic [W-1:0]     max_res;
   logic [W-1:0]     rnd_p;
   logic [3:0]       rnd_flags;

   // Rounding datapath: increment decision, carry renormalisation, range checks
   always_comb begin
      grs = g_q | r_q | s_q;
      case (rnd_q)
         2'b00:   inc = g_q & (r_q | s_q | man_q[0]);   // nearest, ties to even
         2'b01:   inc = 1'b0;                           // toward zero
         2'b10:   inc = ~sign_q & grs;                  // toward +inf
         default: inc = sign_q & grs;                   // toward -inf
      endcase
      mant_r  = {1'b0, 1'b1, man_q} + {{(MAN_W+1){1'b0}}, inc};
      // A carry out of the significand means it became 10.000..0
      exp_r   = exp_q + {{(XW-1){1'b0}}, mant_r[MAN_W+1]};
      frac_r  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
      inf_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      max_res = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      rnd_p     = {sign_q, exp_r[EXP_W-1:0], frac_r};
      rnd_flags = {3'b000, grs};
      if ($signed(exp_r) >= $signed(EXP_ONES)) begin
         rnd_flags = 4'b0101;
         case (rnd_q)
            2'b00:   rnd_p = inf_res;
            2'b01:   rnd_p = max_res;
            2'b10:   rnd_p = sign_q ? max_res : inf_res;
            default: rnd_p = sign_q ? inf_res : max_res;
         endcase
      end else if ($signed(exp_r) < $signed(EXP_ONE)) begin
         rnd_flags = 4'b0011;
         rnd_p     = {sign_q, {(W-1){1'b0}}};
      end
   end

   // Next-state and datapath update for every phase of the operation
   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      rnd_d        = rnd_q;
      sign_d       = sign_q;
      exp_d        = exp_q;
      spec_d       = spec_q;
      spec_p_d     = spec_p_q;
      spec_flags_d = spec_flags_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      man_d        = man_q;
      g_d          = g_q;
      r_d          = r_q;
      s_d          = s_q;
      p_d          = p_q;
      flags_d      = flags_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               a_d     = a;
               b_d     = b;
               rnd_d   = rnd_mode;
               state_d = S_UNPACK;
            end
         end

         S_UNPACK: begin
            sign_d   = sgn;
            mcand_d  = {{(PW-SW){1'b0}}, 1'b1, fa};
            mplier_d = {1'b1, fb};
            acc_d    = '0;
            cnt_d    = CNT_INIT;
            exp_d    = {2'b00, ea} + {2'b00, eb} - BIAS;
            // Specials skip MULT and NORM; ROUND forwards the prepared result.
            spec_d       = 1'b1;
            spec_flags_d = 4'b0000;
            state_d      = S_ROUND;
            if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
               spec_p_d     = QNAN;
               spec_flags_d = 4'b1000;
            end else if (inf_a || inf_b) begin
               spec_p_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (zero_a || zero_b) begin
               spec_p_d = {sgn, {(W-1){1'b0}}};
            end else begin
               spec_d  = 1'b0;
               state_d = S_MULT;
            end
         end

         S_MULT: begin
            // One multiplier bit per cycle, LSB first
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = S_NORM;
            end
         end

         S_NORM: begin
            if (norm_hi) begin
               exp_d = exp_q + EXP_ONE;
               man_d = acc_q[PW-2 -: MAN_W];
               g_d   = acc_q[MAN_W];
               r_d   = acc_q[MAN_W-1];
               s_d   = |acc_q[MAN_W-2:0];
            end else begin
               man_d = acc_q[PW-3 -: MAN_W];
               g_d   = acc_q[MAN_W-1];
               r_d   = acc_q[MAN_W-2];
               s_d   = |acc_q[MAN_W-3:0];
            end
            state_d = S_ROUND;
         end

         S_ROUND: begin
            if (spec_q) begin
               p_d     = spec_p_q;
               flags_d = spec_flags_q;
            end else begin
               p_d     = rnd_p;
               flags_d = rnd_flags;
            end
            state_d = S_DONE;
         end

         default: state_d = S_IDLE;
      endcase

      done_d = (state_d == S_DONE);
      busy_d = (state_d inside {S_UNPACK, S_MULT, S_NORM, S_ROUND});
   end

   // State and output registers; reset abandons any in-flight operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         rnd_q        <= '0;
         sign_q       <= 1'b0;
         exp_q        <= '0;
         spec_q       <= 1'b0;
         spec_p_q     <= '0;
         spec_flags_q <= '0;
         mcand_q      <= '0;
         mplier_q     <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         man_q        <= '0;
         g_q          <= 1'b0;
         r_q          <= 1'b0;
         s_q          <= 1'b0;
         p_q          <= '0;
         flags_q      <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rnd_q        <= rnd_d;
         sign_q       <= sign_d;
         exp_q        <= exp_d;
         spec_q       <= spec_d;
         spec_p_q     <= spec_p_d;
         spec_flags_q <= spec_flags_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         man_q        <= man_d;
         g_q          <= g_d;
         r_q          <= r_d;
         s_q          <= s_d;
         p_q          <= p_d;
         flags_q      <= flags_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign p     = p_q;
   assign flags = flags_q;

endmodule
